// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer arbiter.
package fb_pkg;

    localparam int WORD_W         = 24;
    localparam int ADDR_W         = 16;
    localparam int WORDS_PER_LINE = 80;
    localparam int V_ACTIVE       = 480;
    localparam int FRAME_WORDS    = V_ACTIVE * WORDS_PER_LINE;

    localparam int LINE_W    = 10;
    localparam int LB_ADDR_W = 7;

    // Sticky error bit positions
    localparam int ERR_BUSY  = 0;
    localparam int ERR_RANGE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fb_state_t;

    // First RAM word of a given line; the range is checked before use so
    // the product never wraps.
    function automatic logic [ADDR_W-1:0] line_base(input logic [LINE_W-1:0] line);
        return ADDR_W'(line) * ADDR_W'(WORDS_PER_LINE);
    endfunction

endpackage

// File: rtl/fb_mem_arbiter_if.sv
// Bus bundle between the arbiter and its neighbours: capture writer,
// line request, scanout line buffer, frame RAM and error status.
interface fb_mem_arbiter_if;
    import fb_pkg::*;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_W-1:0]     wr_addr;
    logic [WORD_W-1:0]     wr_data;

    logic                  rd_line_req;
    logic [LINE_W-1:0]     rd_line;
    logic                  rd_busy;
    logic                  rd_line_done;

    logic                  lb_we;
    logic [LB_ADDR_W-1:0]  lb_addr;
    logic [WORD_W-1:0]     lb_wdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [WORD_W-1:0]     mem_wdata;
    logic [WORD_W-1:0]     mem_rdata;

    logic [1:0]            err;
    logic                  err_clr;

    // Arbiter side
    modport master (
        input  wr_valid, wr_addr, wr_data,
        input  rd_line_req, rd_line,
        input  mem_rdata, err_clr,
        output wr_ready, rd_busy, rd_line_done,
        output lb_we, lb_addr, lb_wdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output err
    );

    // Environment side (capture, scanout, RAM)
    modport slave (
        output wr_valid, wr_addr, wr_data,
        output rd_line_req, rd_line,
        output mem_rdata, err_clr,
        input  wr_ready, rd_busy, rd_line_done,
        input  lb_we, lb_addr, lb_wdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  err
    );

endinterface

// File: rtl/fb_mem_arbiter.sv
// Single-port frame RAM arbiter: fetches one scanout line into the line
// buffer on request while guaranteeing capture writes a slot every
// WR_SLOT_INTERVAL reads.
module fb_mem_arbiter
    import fb_pkg::*;
#(
    parameter int WR_SLOT_INTERVAL = 8
) (
    input  logic               clk_in,
    input  logic               rst_n,
    fb_mem_arbiter_if.master   bus
);

    localparam int SLOT_W = $clog2(WR_SLOT_INTERVAL + 1);
    localparam logic [SLOT_W-1:0]    SLOT_FULL   = SLOT_W'(WR_SLOT_INTERVAL);
    localparam logic [LINE_W-1:0]    LINE_LIMIT  = LINE_W'(V_ACTIVE);
    localparam logic [LB_ADDR_W-1:0] LAST_WORD   = LB_ADDR_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0]    FRAME_LIMIT = ADDR_W'(FRAME_WORDS);

    fb_state_t              state_reg, state_next;
    logic [ADDR_W-1:0]      base_reg, base_next;
    logic [LB_ADDR_W-1:0]   word_idx_reg, word_idx_next;
    logic [SLOT_W-1:0]      slot_cnt_reg, slot_cnt_next;
    logic [1:0]             err_reg, err_next;
    logic                   lb_we_reg;
    logic [LB_ADDR_W-1:0]   lb_addr_reg;

    logic                   slot_open;
    logic                   wr_xfer;
    logic                   wr_in_range;
    logic                   rd_issue;
    logic [1:0]             err_set;

    // Write slot availability depends only on state and the slot counter;
    // nothing may be accepted while reset is asserted.
    always_comb begin
        slot_open = 1'b0;
        case (state_reg)
            ST_IDLE:  slot_open = 1'b1;
            ST_FETCH: slot_open = (slot_cnt_reg == SLOT_FULL);
            ST_DRAIN: slot_open = 1'b1;
            default:  slot_open = 1'b0;
        endcase
    end

    assign bus.wr_ready = rst_n & slot_open;
    assign wr_xfer      = bus.wr_ready & bus.wr_valid;
    assign wr_in_range  = (bus.wr_addr < FRAME_LIMIT);

    // Next-state logic: line request handling, read issue and slot counting
    always_comb begin
        state_next    = state_reg;
        base_next     = base_reg;
        word_idx_next = word_idx_reg;
        slot_cnt_next = slot_cnt_reg;
        rd_issue      = 1'b0;
        err_set       = 2'b00;

        case (state_reg)
            ST_IDLE: begin
                if (bus.rd_line_req) begin
                    if (bus.rd_line < LINE_LIMIT) begin
                        base_next     = line_base(bus.rd_line);
                        word_idx_next = '0;
                        slot_cnt_next = '0;
                        state_next    = ST_FETCH;
                    end else begin
                        err_set[ERR_RANGE] = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (bus.rd_line_req) begin
                    err_set[ERR_BUSY] = 1'b1;
                end
                if (wr_xfer) begin
                    // Capture owns this cycle; the read resumes next cycle
                    slot_cnt_next = '0;
                end else begin
                    rd_issue      = 1'b1;
                    word_idx_next = word_idx_reg + LB_ADDR_W'(1);
                    if (slot_cnt_reg != SLOT_FULL) begin
                        slot_cnt_next = slot_cnt_reg + SLOT_W'(1);
                    end
                    if (word_idx_reg == LAST_WORD) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.rd_line_req) begin
                    err_set[ERR_BUSY] = 1'b1;
                end
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A new error in the same cycle as a clear still sets the bit
        err_next = (bus.err_clr ? 2'b00 : err_reg) | err_set;
    end

    // State, counters, error flags and the one-cycle read return pipe
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            base_reg     <= '0;
            word_idx_reg <= '0;
            slot_cnt_reg <= '0;
            err_reg      <= '0;
            lb_we_reg    <= 1'b0;
            lb_addr_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            base_reg     <= base_next;
            word_idx_reg <= word_idx_next;
            slot_cnt_reg <= slot_cnt_next;
            err_reg      <= err_next;
            lb_we_reg    <= rd_issue;
            lb_addr_reg  <= rd_issue ? word_idx_reg : '0;
        end
    end

    // RAM port: a read during FETCH, otherwise an accepted in-range write.
    // Out-of-range writes complete the handshake but never reach the RAM.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (rd_issue) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = base_reg + ADDR_W'(word_idx_reg);
        end else if (wr_xfer && wr_in_range) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = bus.wr_addr;
            bus.mem_wdata = bus.wr_data;
        end
    end

    assign bus.lb_we        = lb_we_reg;
    assign bus.lb_addr      = lb_addr_reg;
    assign bus.lb_wdata     = lb_we_reg ? bus.mem_rdata : '0;
    assign bus.rd_busy      = (state_reg != ST_IDLE);
    assign bus.rd_line_done = (state_reg == ST_DRAIN);
    assign bus.err          = err_reg;

endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
- Shares the single-port frame-buffer RAM between two requesters: the STN capture writer and the HDMI scanout line prefetcher.
- On each line request it fetches one full line of packed pixel words into the external scanout line buffer.
- Capture writes are guaranteed a bounded share of the port while a fetch is in progress.
- Sits between the capture path, the frame RAM and the scanout line buffer that feeds the HDMI timing generator's pixel_data.

Parameters:
- WORD_W, 24, RAM word width (8 pixels x 3 bits).
- ADDR_W, 16, RAM word address width.
- WORDS_PER_LINE, 80, words per active line (640 px / 8).
- V_ACTIVE, 480, active lines; valid rd_line range is 0..V_ACTIVE-1.
- WR_SLOT_INTERVAL, 8, consecutive read issues after which a write slot is offered.

Ports:
- clk_in  in  1  pixel/system clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  capture write request
- wr_ready  out  1  write accepted this cycle when wr_valid is also high
- wr_addr  in  ADDR_W  capture word address
- wr_data  in  WORD_W  capture word data
- rd_line_req  in  1  single-cycle pulse: fetch line rd_line
- rd_line  in  10  line number, sampled with rd_line_req
- rd_busy  out  1  fetch in progress
- rd_line_done  out  1  single-cycle pulse: line fully delivered
- lb_we  out  1  line buffer write strobe
- lb_addr  out  7  line buffer word index, 0..WORDS_PER_LINE-1
- lb_wdata  out  WORD_W  line buffer data
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  WORD_W  RAM write data
- mem_rdata  in  WORD_W  RAM read data, valid 1 cycle after read issue
- err  out  2  sticky errors: bit0 request while busy, bit1 rd_line out of range
- err_clr  in  1  clears err

Behaviour:
- Reset (async, rst_n low):
  - State returns to IDLE and counters clear.
  - All registered outputs are 0: rd_busy, rd_line_done, lb_we, lb_addr, lb_wdata, mem_*, err.
  - wr_ready is forced 0 while rst_n is low.
  - An in-flight fetch is abandoned without rd_line_done.
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - wr_ready=1.
  - rd_line_req with rd_line < V_ACTIVE: base = rd_line*WORDS_PER_LINE is latched, word_idx=0, slot_cnt=0, next state FETCH.
  - rd_line >= V_ACTIVE: request dropped, err[1] set, stay in IDLE.
- FETCH:
  - wr_ready=1 only when slot_cnt==WR_SLOT_INTERVAL.
  - If wr_ready && wr_valid: the cycle is a write and slot_cnt clears.
  - Otherwise the cycle issues a read at base+word_idx, word_idx increments, and slot_cnt increments, saturating at WR_SLOT_INTERVAL.
  - After the read with word_idx==WORDS_PER_LINE-1 is issued, next state is DRAIN.
- DRAIN:
  - Lasts one cycle; the last lb_we occurs here, rd_line_done=1 and wr_ready=1.
  - Next state is IDLE.
- Read return path:
  - lb_we/lb_addr are mem read issue delayed 1 cycle.
  - lb_wdata = mem_rdata in that cycle.
- Writes:
  - On transfer, mem_en=mem_we=1 in the same cycle, with mem_addr=wr_addr and mem_wdata=wr_data.
  - A write with wr_addr >= V_ACTIVE*WORDS_PER_LINE is accepted (wr_ready handshake completes) but dropped, with mem_we=0.
- wr_ready is a function of state and slot_cnt only; it never depends on wr_valid.
- Any cycle without a read issue or write has mem_en=0.
- rd_busy = state != IDLE.
- rd_line_req while busy: ignored, err[0] set, the current fetch continues.
- Simultaneous err_clr and a new error: set wins.
- Fetch latency with no writes: request at cycle t gives reads at t+1..t+W and rd_line_done at t+W+1, where W=WORDS_PER_LINE.
- Address arithmetic: ADDR_W unsigned; multiply by a constant parameter, no wrap within range.

Decomposition:
- Shared package fb_pkg holds:
  - the state enum;
  - WORD_W, ADDR_W, WORDS_PER_LINE and V_ACTIVE localparams;
  - the FRAME_WORDS constant;
  - the err bit indices.
- No sub-module: the 1-cycle read return pipe and address generation stay inline.

Test Plan:
- Reset mid-fetch: assert rst_n low at word 30 -> all outputs 0 immediately; no rd_line_done; a new request after release fetches from word 0.
- Idle fetch, line 3, wr_valid=0, RAM preloaded word[i]=i -> mem_addr 240..319 on cycles t+1..t+80; lb_addr 0..79 carrying data 240..319; rd_line_done at t+81.
- Continuous wr_valid during a fetch of line 0 -> exactly 9 writes, each after 8 reads; rd_line_done at t+90; the written words are present in RAM.
- rd_line_req during a fetch -> err=2'b01; the original fetch completes unchanged. Then err_clr -> err=0.
- rd_line=480 -> no memory access, err[1]=1, rd_busy stays 0.
- Write to address 38400 in IDLE -> wr_ready=1, mem_we=0, RAM unchanged.
